// File: rtl/word_accum_pkg.sv
// Shared defaults, FSM encoding and buffer depth for the word accumulator.
package word_accum_pkg;

    localparam int unsigned DefDw     = 32;
    localparam int unsigned DefSw     = 40;
    localparam int unsigned DefLen    = 4;
    localparam int unsigned BufDepth  = 2;

    // IDLE: no words collected in the current group; RUN: partial group open.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/word_accum_fifo2.sv
// Two-entry synchronous FIFO holding {group sum, partial flag} results.
module word_accum_fifo2
    import word_accum_pkg::*;
#(
    parameter int unsigned W = DefSw + 1
) (
    input  logic         clk,
    input  logic         rst_x,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [BufDepth];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    // Qualify requests against occupancy and work out the next count.
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q < 2'(BufDepth)) || do_pop);
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; contents are discarded on reset.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            for (int i = 0; i < int'(BufDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/word_accum.sv
// Sums fixed-length groups of input words and queues each sum for downstream;
// a flush pulse closes a partial group early.
module word_accum
    import word_accum_pkg::*;
#(
    parameter int unsigned DW  = DefDw,
    parameter int unsigned LEN = DefLen,
    parameter int unsigned SW  = DefSw
) (
    input  logic          clk,
    input  logic          rst_x,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          i_ready,
    input  logic          i_flush,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [SW-1:0] o_sum,
    output logic          o_partial,
    output logic [15:0]   o_grp_cnt
);

    state_e        state_q;
    logic [SW-1:0] acc_q;
    logic [7:0]    cnt_q;
    logic          flush_pend_q;
    logic [15:0]   grp_cnt_q;

    logic [1:0]    buf_count;
    logic [SW:0]   buf_head;
    logic          slot_free;
    logic          accept;
    logic          last_word;
    logic          flush_req;
    logic          flush_exec;
    logic [SW-1:0] sum_in;
    logic          push;
    logic [SW-1:0] push_sum;
    logic          push_partial;

    // Handshake qualification and the result pushed this cycle, if any.
    always_comb begin
        slot_free    = buf_count < 2'(BufDepth);
        accept       = i_valid && slot_free;
        last_word    = cnt_q == 8'(LEN - 1);
        flush_req    = i_flush || flush_pend_q;
        flush_exec   = flush_req && slot_free;
        sum_in       = acc_q + SW'(i_data);
        push         = 1'b0;
        push_sum     = acc_q;
        push_partial = 1'b0;
        if (accept && last_word) begin
            // A completing word wins over a same-cycle flush.
            push     = 1'b1;
            push_sum = sum_in;
        end else if (flush_exec && ((state_q == StRun) || accept)) begin
            push         = 1'b1;
            push_sum     = accept ? sum_in : acc_q;
            push_partial = 1'b1;
        end
    end

    // FSM, accumulator, deferred flush and group counter.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            cnt_q        <= 8'd0;
            flush_pend_q <= 1'b0;
            grp_cnt_q    <= 16'd0;
        end else begin
            if (push) begin
                state_q <= StIdle;
                acc_q   <= '0;
                cnt_q   <= 8'd0;
            end else if (accept) begin
                state_q <= StRun;
                acc_q   <= sum_in;
                cnt_q   <= cnt_q + 8'd1;
            end
            // A flush that cannot execute waits for a free slot.
            flush_pend_q <= flush_req && !slot_free;
            if (push) begin
                grp_cnt_q <= grp_cnt_q + 16'd1;
            end
        end
    end

    word_accum_fifo2 #(
        .W (SW + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_x (rst_x),
        .push  (push),
        .wdata ({push_sum, push_partial}),
        .pop   (o_valid && o_ready),
        .count (buf_count),
        .head  (buf_head)
    );

    assign i_ready   = slot_free;
    assign o_valid   = buf_count != 2'd0;
    assign o_sum     = buf_head[SW:1];
    assign o_partial = buf_head[0];
    assign o_grp_cnt = grp_cnt_q;

endmodule

// File: tb/tb_word_accum.sv
// Directed bench for word_accum with a scoreboard of expected group results.
module tb_word_accum;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        i_valid, i_flush, o_ready;
    logic [31:0] i_data;
    logic        i_ready, o_valid, o_partial;
    logic [39:0] o_sum;
    logic [15:0] o_grp_cnt;

    logic        b_valid, b_flush, b_oready;
    logic [31:0] b_data;
    logic        b_iready, b_ovalid, b_partial;
    logic [39:0] b_sum;
    logic [15:0] b_grp;
    logic        c_iready, c_ovalid, c_partial;
    logic [31:0] c_sum;
    logic [15:0] c_grp;

    int errors = 0;
    int checks = 0;
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    word_accum u_dut (
        .clk (clk), .rst_x (rst_x), .i_valid (i_valid), .i_data (i_data),
        .i_ready (i_ready), .i_flush (i_flush), .o_valid (o_valid), .o_ready (o_ready),
        .o_sum (o_sum), .o_partial (o_partial), .o_grp_cnt (o_grp_cnt)
    );

    word_accum #(.LEN (255), .SW (40)) u_big (
        .clk (clk), .rst_x (rst_x), .i_valid (b_valid), .i_data (b_data),
        .i_ready (b_iready), .i_flush (b_flush), .o_valid (b_ovalid), .o_ready (b_oready),
        .o_sum (b_sum), .o_partial (b_partial), .o_grp_cnt (b_grp)
    );

    word_accum #(.LEN (255), .SW (32)) u_big32 (
        .clk (clk), .rst_x (rst_x), .i_valid (b_valid), .i_data (b_data),
        .i_ready (c_iready), .i_flush (b_flush), .o_valid (c_ovalid), .o_ready (b_oready),
        .o_sum (c_sum), .o_partial (c_partial), .o_grp_cnt (c_grp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; holds the word until accepted, returns at posedge+1.
    task automatic send_word(input logic [31:0] d);
        bit ok = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = i_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        i_valid = 1'b0;
        step(1);
    endtask

    // Scoreboard: every handshake on the result side pops one expected entry.
    always @(negedge clk) begin
        if (rst_x && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", {23'd0, o_sum, o_partial}, 64'd0);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                check("sb_sum", 64'(o_sum), 64'(e[40:1]));
                check("sb_partial", 64'(o_partial), 64'(e[0]));
            end
        end
    end

    initial begin
        rst_x = 1'b0; i_valid = 1'b0; i_data = '0; i_flush = 1'b0; o_ready = 1'b1;
        b_valid = 1'b0; b_data = '0; b_flush = 1'b0; b_oready = 1'b1;
        #2;
        check("rst_i_ready", 64'(i_ready), 64'd1);
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_sum", 64'(o_sum), 64'd0);
        check("rst_o_partial", 64'(o_partial), 64'd0);
        check("rst_grp_cnt", 64'(o_grp_cnt), 64'd0);
        #10 rst_x = 1'b1;
        step(1);

        // Basic group 1,2,3,4 -> 10.
        exp_q.push_back({40'd10, 1'b0});
        send_word(1); send_word(2); send_word(3); send_word(4);
        check("basic_valid", 64'(o_valid), 64'd1);
        check("basic_sum", 64'(o_sum), 64'd10);
        check("basic_partial", 64'(o_partial), 64'd0);
        check("basic_grp_cnt", 64'(o_grp_cnt), 64'd1);
        idle();

        // Backpressure: three groups of 1s with o_ready low.
        o_ready = 1'b0;
        repeat (3) exp_q.push_back({40'd4, 1'b0});
        repeat (4) send_word(1);
        check("bp_ready_one_held", 64'(i_ready), 64'd1);
        repeat (4) send_word(1);
        check("bp_ready_full", 64'(i_ready), 64'd0);
        i_valid = 1'b0;
        step(3);
        check("bp_ready_stays_low", 64'(i_ready), 64'd0);
        check("bp_head_stable", 64'(o_sum), 64'd4);
        o_ready = 1'b1;
        repeat (4) send_word(1);
        idle();
        step(3);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        check("bp_grp_cnt", 64'(o_grp_cnt), 64'd4);

        // Flush closes 5,6 as a partial group; next full group is normal.
        exp_q.push_back({40'd11, 1'b1});
        send_word(5); send_word(6);
        i_valid = 1'b0;
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        check("flush_valid", 64'(o_valid), 64'd1);
        check("flush_sum", 64'(o_sum), 64'd11);
        check("flush_partial", 64'(o_partial), 64'd1);
        exp_q.push_back({40'd4, 1'b0});
        repeat (4) send_word(1);
        idle();
        step(3);
        check("flush_grp_cnt", 64'(o_grp_cnt), 64'd6);

        // Flush while the buffer is full: word 7 waits, pending flush closes it.
        o_ready = 1'b0;
        repeat (2) exp_q.push_back({40'd4, 1'b0});
        repeat (8) send_word(1);
        i_valid = 1'b1;
        i_data  = 32'd7;
        step(2);
        check("full_word_refused", 64'(i_ready), 64'd0);
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        check("full_no_push_yet", 64'(o_grp_cnt), 64'd8);
        o_ready = 1'b1;
        step(1);
        o_ready = 1'b0;
        exp_q.push_back({40'd7, 1'b1});
        step(1);
        i_valid = 1'b0;
        check("full_flush_push", 64'(o_grp_cnt), 64'd9);
        check("full_again", 64'(i_ready), 64'd0);
        o_ready = 1'b1;
        step(4);
        check("full_drained", 64'(exp_q.size()), 64'd0);

        // LEN=255 of all-ones: 40-bit keeps the carry, 32-bit wraps.
        b_valid = 1'b1;
        b_data  = 32'hFFFF_FFFF;
        step(255);
        b_valid = 1'b0;
        check("wrap40_valid", 64'(b_ovalid), 64'd1);
        check("wrap40_sum", 64'(b_sum), 64'hFE_FFFF_FF01);
        check("wrap40_partial", 64'(b_partial), 64'd0);
        check("wrap32_sum", 64'(c_sum), 64'hFFFF_FF01);
        step(1);

        // Async reset mid-group with a held result discards everything.
        o_ready = 1'b0;
        repeat (4) send_word(1);
        send_word(9); send_word(9);
        i_valid = 1'b0;
        check("prereset_valid", 64'(o_valid), 64'd1);
        #2 rst_x = 1'b0;
        #1;
        check("arst_i_ready", 64'(i_ready), 64'd1);
        check("arst_o_valid", 64'(o_valid), 64'd0);
        check("arst_o_sum", 64'(o_sum), 64'd0);
        check("arst_grp_cnt", 64'(o_grp_cnt), 64'd0);
        rst_x = 1'b1;
        step(1);
        o_ready = 1'b1;
        exp_q.push_back({40'd4, 1'b0});
        repeat (4) send_word(1);
        check("post_reset_sum", 64'(o_sum), 64'd4);
        check("post_reset_grp_cnt", 64'(o_grp_cnt), 64'd1);
        idle();
        step(3);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
